pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_pkg.sv | 25 ++
 rtl/pipe_hazard_ctrl_fwd_unit.sv | 27 ++
 rtl/pipe_hazard_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: stage indices,
// forwarding-select encodings and debug single-step FSM states.
package pipe_hazard_ctrl_pkg;

    localparam int unsigned NUM_STAGES = 5;
    localparam int unsigned STG_IF     = 0;
    localparam int unsigned STG_ID     = 1;
    localparam int unsigned STG_EXE    = 2;
    localparam int unsigned STG_MEM    = 3;
    localparam int unsigned STG_WB     = 4;

    typedef enum logic [1:0] {
        FWD_RF       = 2'd0,
        FWD_MEM_ALU  = 2'd1,
        FWD_WB       = 2'd2,
        FWD_MEM_LOAD = 2'd3
    } fwd_sel_e;

    typedef enum logic [1:0] {
        DBG_RUN  = 2'd0,
        DBG_HALT = 2'd1,
        DBG_STEP = 2'd2
    } dbg_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Operand forwarding select for one EXE source register; MEM beats WB, r0 never forwarded.
module fwd_unit
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned AW = 5
) (
    input  logic [AW-1:0] exe_addr,
    input  logic [AW-1:0] mem_regw_addr,
    input  logic          mem_wb_wen,
    input  logic          mem_is_load,
    input  logic [AW-1:0] wb_regw_addr,
    input  logic          wb_wb_wen,
    output logic [1:0]    fwd_sel
);

    always_comb begin
        fwd_sel = FWD_RF;
        if (exe_addr != '0) begin
            if (mem_wb_wen && (exe_addr == mem_regw_addr)) begin
                fwd_sel = mem_is_load ? FWD_MEM_LOAD : FWD_MEM_ALU;
            end else if (wb_wb_wen && (exe_addr == wb_regw_addr)) begin
                fwd_sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: freeze on memory wait, load-use bubble,
// branch flush, forwarding and perf counters. Optional DEBUG_STEP_EN adds halt/single-step.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef DEBUG_STEP_EN
    input  logic                  debug_en,
    input  logic                  debug_step,
`endif
    input  logic [REG_AW-1:0]     id_rs_addr,
    input  logic [REG_AW-1:0]     id_rt_addr,
    input  logic                  id_rs_used,
    input  logic                  id_rt_used,
    input  logic                  id_branch_taken,
    input  logic [REG_AW-1:0]     exe_rs_addr,
    input  logic [REG_AW-1:0]     exe_rt_addr,
    input  logic [REG_AW-1:0]     exe_regw_addr,
    input  logic                  exe_wb_wen,
    input  logic                  exe_is_load,
    input  logic [REG_AW-1:0]     mem_regw_addr,
    input  logic [REG_AW-1:0]     wb_regw_addr,
    input  logic                  mem_wb_wen,
    input  logic                  wb_wb_wen,
    input  logic                  mem_is_load,
    input  logic                  mem_access,
    input  logic                  inst_ack,
    input  logic                  mem_ack,
    output logic                  inst_ren,
    output logic                  mem_ren,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic [NUM_STAGES-1:0] stage_flush,
    output logic [NUM_STAGES-1:0] stage_valid,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  wait_timeout,
    output logic [CNT_W-1:0]      cyc_cnt,
    output logic [CNT_W-1:0]      bubble_cnt,
    output logic [CNT_W-1:0]      wait_cnt
);

    localparam int unsigned RUN_W = $clog2(WAIT_MAX + 1);

    logic [NUM_STAGES-1:0] stage_valid_q, stage_valid_d;
    logic [CNT_W-1:0]      cyc_cnt_q, cyc_cnt_d;
    logic [CNT_W-1:0]      bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic [RUN_W-1:0]      run_len_q, run_len_d;
    logic                  wait_timeout_q, wait_timeout_d;
    logic                  mem_wait, freeze, halt, load_use, src_match;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    // Stall/flush decision; memory wait or debug halt dominates a load-use bubble.
    always_comb begin
        inst_ren    = rst & stage_valid_q[STG_IF];
        mem_ren     = rst & stage_valid_q[STG_MEM] & mem_access;
        mem_wait    = (inst_ren & ~inst_ack) | (mem_ren & ~mem_ack);
        freeze      = mem_wait | halt;
        src_match   = (id_rs_used & (id_rs_addr == exe_regw_addr))
                    | (id_rt_used & (id_rt_addr == exe_regw_addr));
        load_use    = exe_is_load & exe_wb_wen & (exe_regw_addr != '0) & src_match;
        stage_en    = '1;
        stage_flush = '0;
        if (!rst || freeze) begin
            stage_en = '0;
        end else if (load_use) begin
            stage_en[STG_IF]     = 1'b0;
            stage_en[STG_ID]     = 1'b0;
            stage_flush[STG_EXE] = 1'b1;
        end else begin
            stage_flush[STG_ID] = id_branch_taken;
        end
    end

    always_comb begin
        stage_valid_d = stage_valid_q;
        stage_valid_d[STG_IF] = stage_en[STG_IF] | stage_valid_q[STG_IF];
        stage_valid_d[STG_WB:STG_ID] =
              (stage_en[STG_WB:STG_ID] & stage_valid_q[STG_MEM:STG_IF] & ~stage_flush[STG_WB:STG_ID])
            | (~stage_en[STG_WB:STG_ID] & stage_valid_q[STG_WB:STG_ID]);

        cyc_cnt_d    = sat_inc(cyc_cnt_q, 1'b1);
        bubble_cnt_d = sat_inc(bubble_cnt_q, load_use & ~freeze);
        wait_cnt_d   = sat_inc(wait_cnt_q, mem_wait);
        run_len_d    = '0;
        if (mem_wait) begin
            run_len_d = (run_len_q == RUN_W'(WAIT_MAX)) ? run_len_q : run_len_q + RUN_W'(1);
        end
        wait_timeout_d = wait_timeout_q | (run_len_d == RUN_W'(WAIT_MAX));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_valid_q  <= '0;
            cyc_cnt_q      <= '0;
            bubble_cnt_q   <= '0;
            wait_cnt_q     <= '0;
            run_len_q      <= '0;
            wait_timeout_q <= 1'b0;
        end else begin
            stage_valid_q  <= stage_valid_d;
            cyc_cnt_q      <= cyc_cnt_d;
            bubble_cnt_q   <= bubble_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            run_len_q      <= run_len_d;
            wait_timeout_q <= wait_timeout_d;
        end
    end

`ifdef DEBUG_STEP_EN
    dbg_state_e dbg_state_q, dbg_state_d;
    logic       step_meta_q, step_sync_q, step_prev_q;

    // Single-step: one advance per synchronised step edge; STEP waits out memory freezes.
    always_comb begin
        dbg_state_d = dbg_state_q;
        case (dbg_state_q)
            DBG_RUN:  if (debug_en) dbg_state_d = DBG_HALT;
            DBG_HALT: begin
                if (!debug_en) begin
                    dbg_state_d = DBG_RUN;
                end else if (step_sync_q && !step_prev_q) begin
                    dbg_state_d = DBG_STEP;
                end
            end
            DBG_STEP: if (!mem_wait) dbg_state_d = DBG_HALT;
            default:  dbg_state_d = DBG_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dbg_state_q <= debug_en ? DBG_HALT : DBG_RUN;
            step_meta_q <= 1'b0;
            step_sync_q <= 1'b0;
            step_prev_q <= 1'b0;
        end else begin
            dbg_state_q <= dbg_state_d;
            step_meta_q <= debug_step;
            step_sync_q <= step_meta_q;
            step_prev_q <= step_sync_q;
        end
    end

    assign halt = (dbg_state_q == DBG_HALT);
`else
    assign halt = 1'b0;
`endif

    fwd_unit #(.AW(REG_AW)) u_fwd_a (
        .exe_addr      (exe_rs_addr),
        .mem_regw_addr (mem_regw_addr),
        .mem_wb_wen    (mem_wb_wen),
        .mem_is_load   (mem_is_load),
        .wb_regw_addr  (wb_regw_addr),
        .wb_wb_wen     (wb_wb_wen),
        .fwd_sel       (fwd_a_sel)
    );

    fwd_unit #(.AW(REG_AW)) u_fwd_b (
        .exe_addr      (exe_rt_addr),
        .mem_regw_addr (mem_regw_addr),
        .mem_wb_wen    (mem_wb_wen),
        .mem_is_load   (mem_is_load),
        .wb_regw_addr  (wb_regw_addr),
        .wb_wb_wen     (wb_wb_wen),
        .fwd_sel       (fwd_b_sel)
    );

    assign stage_valid  = stage_valid_q;
    assign wait_timeout = wait_timeout_q;
    assign cyc_cnt      = cyc_cnt_q;
    assign bubble_cnt   = bubble_cnt_q;
    assign wait_cnt     = wait_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random traffic against a
// cycle-level reference model of the pipeline rules. Define DEBUG_STEP_EN to cover single-step.
module tb_pipe_hazard_ctrl;

    localparam int unsigned AW   = 5;
    localparam int unsigned CW   = 8;
    localparam int unsigned WMAX = 255;
    localparam int          CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    logic debug_en, debug_step;
    logic [AW-1:0] id_rs_addr, id_rt_addr, exe_rs_addr, exe_rt_addr, exe_regw_addr;
    logic [AW-1:0] mem_regw_addr, wb_regw_addr;
    logic id_rs_used, id_rt_used, id_branch_taken, exe_wb_wen, exe_is_load;
    logic mem_wb_wen, wb_wb_wen, mem_is_load, mem_access, inst_ack, mem_ack;
    logic inst_ren, mem_ren, wait_timeout;
    logic [4:0] stage_en, stage_flush, stage_valid;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic [CW-1:0] cyc_cnt, bubble_cnt, wait_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_AW(AW), .CNT_W(CW), .WAIT_MAX(WMAX)) dut (
        .clk(clk), .rst(rst),
`ifdef DEBUG_STEP_EN
        .debug_en(debug_en), .debug_step(debug_step),
`endif
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_branch_taken(id_branch_taken),
        .exe_rs_addr(exe_rs_addr), .exe_rt_addr(exe_rt_addr),
        .exe_regw_addr(exe_regw_addr), .exe_wb_wen(exe_wb_wen), .exe_is_load(exe_is_load),
        .mem_regw_addr(mem_regw_addr), .wb_regw_addr(wb_regw_addr),
        .mem_wb_wen(mem_wb_wen), .wb_wb_wen(wb_wb_wen), .mem_is_load(mem_is_load),
        .mem_access(mem_access), .inst_ack(inst_ack), .mem_ack(mem_ack),
        .inst_ren(inst_ren), .mem_ren(mem_ren),
        .stage_en(stage_en), .stage_flush(stage_flush), .stage_valid(stage_valid),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .wait_timeout(wait_timeout),
        .cyc_cnt(cyc_cnt), .bubble_cnt(bubble_cnt), .wait_cnt(wait_cnt)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state
    bit [4:0] mv;
    int  m_cyc, m_bub, m_wait, m_run, m_dbg;
    bit  m_tmo;
    bit [2:0] ms;
    bit e_iren, e_mren, e_mw, e_frz, e_haz;
    bit [4:0] e_en, e_fl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= CMAX) ? v : v + 1;
    endfunction

    function automatic int fwd_ref(input int a);
        if (a == 0) return 0;
        if (mem_wb_wen && a == int'(mem_regw_addr)) return mem_is_load ? 3 : 1;
        if (wb_wb_wen && a == int'(wb_regw_addr)) return 2;
        return 0;
    endfunction

    task automatic check_cycle();
        e_iren = rst && mv[0];
        e_mren = rst && mv[3] && mem_access;
        e_mw   = (e_iren && !inst_ack) || (e_mren && !mem_ack);
        e_frz  = e_mw || (m_dbg == 1);
        e_haz  = exe_is_load && exe_wb_wen && exe_regw_addr != 0 &&
                 ((id_rs_used && id_rs_addr == exe_regw_addr) ||
                  (id_rt_used && id_rt_addr == exe_regw_addr));
        if (!rst || e_frz) begin
            e_en = 5'b00000; e_fl = 5'b00000;
        end else if (e_haz) begin
            e_en = 5'b11100; e_fl = 5'b00100;
        end else begin
            e_en = 5'b11111; e_fl = id_branch_taken ? 5'b00010 : 5'b00000;
        end
        chk("inst_ren", 32'(inst_ren), 32'(e_iren));
        chk("mem_ren", 32'(mem_ren), 32'(e_mren));
        chk("stage_en", 32'(stage_en), 32'(e_en));
        chk("stage_flush", 32'(stage_flush), 32'(e_fl));
        chk("stage_valid", 32'(stage_valid), 32'(mv));
        chk("fwd_a_sel", 32'(fwd_a_sel), 32'(fwd_ref(int'(exe_rs_addr))));
        chk("fwd_b_sel", 32'(fwd_b_sel), 32'(fwd_ref(int'(exe_rt_addr))));
        chk("cyc_cnt", 32'(cyc_cnt), 32'(m_cyc));
        chk("bubble_cnt", 32'(bubble_cnt), 32'(m_bub));
        chk("wait_cnt", 32'(wait_cnt), 32'(m_wait));
        chk("wait_timeout", 32'(wait_timeout), 32'(m_tmo));
    endtask

    task automatic tick();
        #1;
        check_cycle();
        @(posedge clk);
        if (!e_frz) begin
            if (e_haz) mv = {mv[3], mv[2], 1'b0, mv[1], mv[0]};
            else       mv = {mv[3], mv[2], mv[1], mv[0] & !id_branch_taken, 1'b1};
        end
        m_cyc = sat(m_cyc);
        if (!e_frz && e_haz) m_bub = sat(m_bub);
        if (e_mw) begin
            m_wait = sat(m_wait);
            if (m_run < int'(WMAX)) m_run++;
        end else begin
            m_run = 0;
        end
        if (m_run >= int'(WMAX)) m_tmo = 1'b1;
`ifdef DEBUG_STEP_EN
        case (m_dbg)
            0: if (debug_en) m_dbg = 1;
            1: if (!debug_en) m_dbg = 0; else if (ms[1] && !ms[2]) m_dbg = 2;
            default: if (!e_mw) m_dbg = 1;
        endcase
        ms = {ms[1], ms[0], debug_step};
`endif
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        mv = '0; m_cyc = 0; m_bub = 0; m_wait = 0; m_run = 0; m_tmo = 1'b0; ms = '0;
`ifdef DEBUG_STEP_EN
        m_dbg = debug_en ? 1 : 0;
`else
        m_dbg = 0;
`endif
        #1;
        check_cycle();
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic idle();
        id_rs_addr = '0; id_rt_addr = '0; id_rs_used = 0; id_rt_used = 0; id_branch_taken = 0;
        exe_rs_addr = '0; exe_rt_addr = '0; exe_regw_addr = '0; exe_wb_wen = 0; exe_is_load = 0;
        mem_regw_addr = '0; wb_regw_addr = '0; mem_wb_wen = 0; wb_wb_wen = 0; mem_is_load = 0;
        mem_access = 0; inst_ack = 1; mem_ack = 1;
    endtask

    task automatic rand_inputs();
        id_rs_addr = AW'($urandom_range(0, 3)); id_rt_addr = AW'($urandom_range(0, 3));
        id_rs_used = 1'($urandom); id_rt_used = 1'($urandom);
        id_branch_taken = ($urandom_range(0, 4) == 0);
        exe_rs_addr = AW'($urandom_range(0, 3)); exe_rt_addr = AW'($urandom_range(0, 3));
        exe_regw_addr = AW'($urandom_range(0, 3));
        exe_wb_wen = 1'($urandom); exe_is_load = 1'($urandom);
        mem_regw_addr = AW'($urandom_range(0, 3)); wb_regw_addr = AW'($urandom_range(0, 3));
        mem_wb_wen = 1'($urandom); wb_wb_wen = 1'($urandom); mem_is_load = 1'($urandom);
        mem_access = 1'($urandom);
        inst_ack = ($urandom_range(0, 7) != 0);
        mem_ack = ($urandom_range(0, 7) != 0);
    endtask

    initial begin
        logic [4:0] v0;
        int w0, adv;
        debug_en = 0; debug_step = 0;
        idle();
        do_reset();
        for (int i = 0; i < 6; i++) tick();

        // Load-use: lw r3 in EXE, add r4,r3,r5 in ID
        exe_regw_addr = 3; exe_is_load = 1; exe_wb_wen = 1;
        id_rs_addr = 3; id_rs_used = 1; id_rt_addr = 5; id_rt_used = 1;
        #1;
        chk("lu_flush2", 32'(stage_flush[2]), 32'd1);
        chk("lu_en", 32'(stage_en), 32'h1c);
        tick();
        chk("lu_bubble_cnt", 32'(bubble_cnt), 32'd1);
        chk("lu_bubble_valid2", 32'(stage_valid[2]), 32'd0);
        idle();
        mem_regw_addr = 3; mem_wb_wen = 1; mem_is_load = 1; mem_access = 1;
        exe_rs_addr = 3; exe_rt_addr = 5; exe_regw_addr = 4; exe_wb_wen = 1;
        #1;
        chk("lu_fwd_a", 32'(fwd_a_sel), 32'd3);
        chk("lu_flush2_clear", 32'(stage_flush[2]), 32'd0);
        tick();

        // Forwarding priority and r0
        idle();
        mem_regw_addr = 2; mem_wb_wen = 1; wb_regw_addr = 2; wb_wb_wen = 1;
        exe_rs_addr = 2;
        #1;
        chk("fwd_mem_over_wb", 32'(fwd_a_sel), 32'd1);
        tick();
        mem_wb_wen = 0;
        #1;
        chk("fwd_wb_only", 32'(fwd_a_sel), 32'd2);
        tick();
        mem_regw_addr = 0; mem_wb_wen = 1; wb_regw_addr = 0; exe_rt_addr = 0;
        #1;
        chk("fwd_r0", 32'(fwd_b_sel), 32'd0);
        tick();

        // inst_ack low for 3 cycles
        idle();
        v0 = stage_valid; w0 = int'(wait_cnt);
        inst_ack = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ifreeze_en", 32'(stage_en), 32'd0);
            tick();
        end
        inst_ack = 1;
        #1;
        chk("ifreeze_wait_cnt", 32'(wait_cnt), 32'(w0 + 3));
        chk("ifreeze_valid_hold", 32'(stage_valid), 32'(v0));
        tick();

        // Branch with no stall, then branch under fetch wait
        id_branch_taken = 1;
        tick();
        id_branch_taken = 0;
        chk("br_valid1", 32'(stage_valid[1]), 32'd0);
        tick();
        tick();
        id_branch_taken = 1; inst_ack = 0;
        tick();
        chk("br_frozen_valid1", 32'(stage_valid[1]), 32'd1);
        tick();
        chk("br_frozen_valid1b", 32'(stage_valid[1]), 32'd1);
        inst_ack = 1;
        tick();
        chk("br_after_ack_valid1", 32'(stage_valid[1]), 32'd0);
        id_branch_taken = 0;
        tick();

`ifdef DEBUG_STEP_EN
        // Halt with two step pulses
        debug_en = 1;
        tick();
        adv = 0;
        for (int i = 0; i < 30; i++) begin
            debug_step = (i >= 2 && i < 5) || (i >= 14 && i < 17);
            #1;
            if (stage_en === 5'h1f) adv++;
            tick();
        end
        chk("dbg_advances", 32'(adv), 32'd2);
        debug_en = 0;
        tick();
        tick();
`endif

        // Data-access wait long enough to time out
        idle();
        mem_access = 1; mem_ack = 0;
        for (int i = 0; i < int'(WMAX) - 1; i++) tick();
        chk("tmo_not_yet", 32'(wait_timeout), 32'd0);
        tick();
        chk("tmo_set", 32'(wait_timeout), 32'd1);
        mem_ack = 1;
        tick();
        tick();
        chk("tmo_sticky", 32'(wait_timeout), 32'd1);
        chk("cyc_saturated", 32'(cyc_cnt), 32'(CMAX));

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            rand_inputs();
            tick();
        end

        // Reset in the middle of a fetch wait
        idle();
        inst_ack = 0;
        tick();
        do_reset();
        chk("rst_timeout_clear", 32'(wait_timeout), 32'd0);
        chk("rst_first_fetch", 32'(inst_ren), 32'd1);
        tick();
        inst_ack = 1;
        for (int i = 0; i < 100; i++) begin
            rand_inputs();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
